fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t     - request-tracking FSM states
//   RESET_PC_DEFAULT  - default first fetch address after reset
//   WORD_BYTES        - fetch address increment per granted request
//   PC_PLUS8_OFFSET   - offset of the architectural PC read value
//   align_word()      - forces an address onto a word boundary
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] PC_PLUS8_OFFSET  = 32'd8;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry FIFO of {instruction, pc} words.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   push, push_data   - write one entry (ignored when full without a pop)
//   pop               - remove head entry (ignored when empty)
//   flush             - empty the FIFO; overrides push and pop
//   head_data         - current head entry (all zero after reset)
//   count, empty      - occupancy
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    // Storage is reset too so the head reads as zero while in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory with at
// most one request outstanding, buffers responses with their addresses and
// hands them in order to the consumer. A redirect flushes the buffer, moves
// the fetch address and discards any in-flight response.
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   imem_req, imem_addr        - fetch request and word address
//   imem_gnt                   - memory accepts the request this cycle
//   imem_rvalid, imem_rdata    - memory response
//   instr, instr_pc            - head instruction and its address
//   instr_pc_plus8             - instr_pc + 8
//   instr_valid, instr_ready   - consumer handshake
//   redirect, redirect_pc      - new fetch address from execute
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | nothing outstanding; may request
// ST_WAIT  | request outstanding, response will be buffered
// ST_DRAIN | request outstanding, response will be discarded
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus8,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_COUNT = CW'(DEPTH);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [31:0]       fetch_pc;
    logic [31:0]       req_pc;
    logic              grant;
    logic              push;
    logic              pop;
    logic [63:0]       head_data;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;

    assign grant = imem_req & imem_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    state_next = redirect ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response coinciding with a redirect is dropped here.
                if (imem_rvalid) begin
                    state_next = ST_IDLE;
                end else if (redirect) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Requesting only from IDLE with a free slot reserves that slot for the
    // response, so the buffer cannot overflow. The reset term keeps the
    // request low while reset is held even though the state already reads IDLE.
    always_comb begin
        imem_req = 1'b0;
        push     = 1'b0;
        if (reset && state == ST_IDLE && fifo_count < DEPTH_COUNT && !redirect) begin
            imem_req = 1'b1;
        end
        if (state == ST_WAIT && imem_rvalid && !redirect) begin
            push = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= align_word(redirect_pc);
            end else if (grant) begin
                fetch_pc <= fetch_pc + WORD_BYTES;
            end
            if (grant) begin
                req_pc <= fetch_pc;
            end
        end
    end

    assign pop       = instr_valid & instr_ready & ~redirect;
    assign imem_addr = fetch_pc;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({imem_rdata, req_pc}),
        .pop       (pop),
        .flush     (redirect),
        .head_data (head_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign instr_valid    = ~fifo_empty;
    assign instr          = head_data[63:32];
    assign instr_pc       = head_data[31:0];
    assign instr_pc_plus8 = instr_pc + PC_PLUS8_OFFSET;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default-parameter instance for streaming,
// back-pressure, redirect and grant-stall sequences, and a second instance
// with RESET_PC = 0xFFFF_FFFC for address wrap and mid-transaction reset.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] plus8;
    logic        valid;

    logic        h_reset;
    logic        h_gnt;
    logic        h_rvalid;
    logic [31:0] h_rdata;
    logic        h_ready;
    logic        h_redirect;
    logic [31:0] h_redirect_pc;
    logic        h_req;
    logic [31:0] h_addr;
    logic [31:0] h_instr;
    logic [31:0] h_pc;
    logic [31:0] h_plus8;
    logic        h_valid;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (req),
        .imem_addr      (addr),
        .imem_gnt       (gnt),
        .imem_rvalid    (rvalid),
        .imem_rdata     (rdata),
        .instr          (instr),
        .instr_pc       (pc),
        .instr_pc_plus8 (plus8),
        .instr_valid    (valid),
        .instr_ready    (ready),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC),
        .DEPTH    (2)
    ) dut_hi (
        .clk            (clk),
        .reset          (h_reset),
        .imem_req       (h_req),
        .imem_addr      (h_addr),
        .imem_gnt       (h_gnt),
        .imem_rvalid    (h_rvalid),
        .imem_rdata     (h_rdata),
        .instr          (h_instr),
        .instr_pc       (h_pc),
        .instr_pc_plus8 (h_plus8),
        .instr_valid    (h_valid),
        .instr_ready    (h_ready),
        .redirect       (h_redirect),
        .redirect_pc    (h_redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 0; gnt = 1; rvalid = 0; rdata = '0; ready = 1;
        redirect = 0; redirect_pc = '0;
        h_reset = 0; h_gnt = 1; h_rvalid = 0; h_rdata = '0; h_ready = 1;
        h_redirect = 0; h_redirect_pc = '0;

        // reset values
        #2;
        chk("rst_req", 32'(req), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_addr", addr, 0);
        tick(); tick();
        chk("rst_req_hold", 32'(req), 0);
        chk("rst_valid_hold", 32'(valid), 0);

        // streaming: 0x0, 0x4, 0x8
        reset = 1; #1;
        chk("first_req", 32'(req), 1);
        chk("first_addr", addr, 32'h0);
        tick();
        rvalid = 1; rdata = 32'hE000_0000; #1;
        chk("wait_no_req", 32'(req), 0);
        tick();
        rvalid = 0; #1;
        chk("s0_valid", 32'(valid), 1);
        chk("s0_pc", pc, 32'h0);
        chk("s0_plus8", plus8, 32'h8);
        chk("s0_instr", instr, 32'hE000_0000);
        chk("s0_next_addr", addr, 32'h4);
        chk("s0_next_req", 32'(req), 1);
        tick();
        rvalid = 1; rdata = 32'hE000_0004; #1;
        chk("s1_bubble", 32'(valid), 0);
        tick();
        rvalid = 0; #1;
        chk("s1_pc", pc, 32'h4);
        chk("s1_plus8", plus8, 32'hC);
        chk("s1_instr", instr, 32'hE000_0004);
        tick();
        rvalid = 1; rdata = 32'hE000_0008; tick();
        rvalid = 0; ready = 0; #1;
        chk("s2_pc", pc, 32'h8);
        chk("s2_plus8", plus8, 32'h10);

        // back-pressure: ready low for 10 cycles, buffer fills to 2
        tick();
        rvalid = 1; rdata = 32'hE000_000C; #1;
        chk("stall_head", pc, 32'h8);
        tick();
        rvalid = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("full_no_req", 32'(req), 0);
            chk("full_hold_pc", pc, 32'h8);
            chk("full_hold_instr", instr, 32'hE000_0008);
            tick();
        end
        ready = 1; #1;
        chk("full_req_rel", 32'(req), 0);
        tick();
        #1;
        chk("rel_pc", pc, 32'hC);
        chk("rel_instr", instr, 32'hE000_000C);
        chk("rel_req", 32'(req), 1);
        chk("rel_addr", addr, 32'h10);
        tick();

        // redirect in WAIT, stale response next cycle
        redirect = 1; redirect_pc = 32'h100; #1;
        chk("redir_valid", 32'(valid), 0);
        chk("redir_no_req", 32'(req), 0);
        tick();
        redirect = 0; rvalid = 1; rdata = 32'hBAD0_0010; #1;
        chk("drain_no_req", 32'(req), 0);
        chk("drain_addr", addr, 32'h100);
        tick();
        rvalid = 0; #1;
        chk("drop_valid", 32'(valid), 0);
        chk("drop_req", 32'(req), 1);
        chk("drop_addr", addr, 32'h100);
        tick();
        rvalid = 1; rdata = 32'hE000_0100; tick();
        rvalid = 0; #1;
        chk("r100_pc", pc, 32'h100);
        chk("r100_instr", instr, 32'hE000_0100);
        tick();

        // redirect to unaligned 0x203 together with rvalid
        rvalid = 1; rdata = 32'hBAD0_0104; redirect = 1; redirect_pc = 32'h203; #1;
        chk("r203_no_req", 32'(req), 0);
        tick();
        rvalid = 0; redirect = 0; #1;
        chk("r203_valid", 32'(valid), 0);
        chk("r203_addr", addr, 32'h200);
        chk("r203_req", 32'(req), 1);

        // grant held low 5 cycles, stray rvalid in IDLE ignored
        gnt = 0;
        for (int i = 0; i < 5; i++) begin
            rvalid = 1; rdata = 32'hBAD0_0200; #1;
            chk("gstall_req", 32'(req), 1);
            chk("gstall_addr", addr, 32'h200);
            chk("idle_rvalid_ignored", 32'(valid), 0);
            tick();
        end
        rvalid = 0; gnt = 1; #1;
        chk("gnt_req", 32'(req), 1);
        chk("gnt_addr", addr, 32'h200);
        tick();
        #1;
        chk("post_gnt_addr", addr, 32'h204);
        rvalid = 1; rdata = 32'hE000_0200; tick();
        rvalid = 0; gnt = 0; ready = 0; #1;
        chk("r200_pc", pc, 32'h200);
        chk("r200_instr", instr, 32'hE000_0200);

        // redirect flushes a non-empty buffer and blocks the request
        redirect = 1; redirect_pc = 32'h400; #1;
        chk("flush_no_req", 32'(req), 0);
        tick();
        redirect = 0; #1;
        chk("flush_valid", 32'(valid), 0);
        chk("flush_addr", addr, 32'h400);
        ready = 1;

        // RESET_PC = 0xFFFF_FFFC: wrap, then reset mid-WAIT
        h_reset = 1; #1;
        chk("hi_first_req", 32'(h_req), 1);
        chk("hi_first_addr", h_addr, 32'hFFFF_FFFC);
        tick();
        h_rvalid = 1; h_rdata = 32'hE0FF_FFFC; #1;
        chk("hi_wrap_addr", h_addr, 32'h0);
        tick();
        h_rvalid = 0; h_ready = 0; #1;
        chk("hi_pc", h_pc, 32'hFFFF_FFFC);
        chk("hi_plus8", h_plus8, 32'h4);
        chk("hi_req2", 32'(h_req), 1);
        chk("hi_addr2", h_addr, 32'h0);
        tick();
        #1;
        chk("hi_wait_req", 32'(h_req), 0);
        chk("hi_wait_addr", h_addr, 32'h4);
        chk("hi_wait_valid", 32'(h_valid), 1);
        h_reset = 0; #1;
        chk("hi_rst_req", 32'(h_req), 0);
        chk("hi_rst_valid", 32'(h_valid), 0);
        chk("hi_rst_instr", h_instr, 32'h0);
        chk("hi_rst_pc", h_pc, 32'h0);
        chk("hi_rst_addr", h_addr, 32'hFFFF_FFFC);
        tick();
        h_gnt = 0; h_rvalid = 1; h_rdata = 32'hBAD0_0004; h_reset = 1; #1;
        chk("hi_rel_req", 32'(h_req), 1);
        chk("hi_rel_addr", h_addr, 32'hFFFF_FFFC);
        tick();
        h_rvalid = 0; #1;
        chk("hi_late_rvalid", 32'(h_valid), 0);
        chk("hi_late_req", 32'(h_req), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
